// File: rtl/axis_spi_mc.sv
// -----------------------------------------------------------------------------
// axis_spi_mc
//
// Multi-target SPI master. Each command selects a chip select, a transfer
// length of 1..DATA_WIDTH bits, a CPOL/CPHA mode, a bit order and a clock
// divider. Received data is returned on a valid/ready response stream.
//
// Ports
//   axis_clk, axis_resetn    : clock, synchronous active-low reset
//   cfg_div                  : half-period select, H = cfg_div + 1 clocks
//   axis_wdata/wcs/wlen/wmode: command fields (data, target, L-1, mode)
//   axis_wvalid/axis_wready  : command handshake
//   axis_rdata/axis_rvalid/axis_rready : response handshake
//   spi_sclk/spi_mosi/spi_miso/spi_cs_n : SPI bus
//   busy                     : high from accept until the end of GAP
//   dbg_state                : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holds valid and its payload stable until that edge;
// ready may be asserted without valid. axis_wready is registered and only
// asserted in IDLE when no unread response is pending, so a held response
// blocks the next command and no response is ever overwritten.
// -----------------------------------------------------------------------------
module axis_spi_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 4,
  parameter int CS_W       = 2,
  parameter int LEN_W      = 5,
  parameter int DIV_BITS   = 8
) (
  input  logic                  axis_clk,
  input  logic                  axis_resetn,
  input  logic [DIV_BITS-1:0]   cfg_div,
  input  logic [DATA_WIDTH-1:0] axis_wdata,
  input  logic [CS_W-1:0]       axis_wcs,
  input  logic [LEN_W-1:0]      axis_wlen,
  input  logic [2:0]            axis_wmode,
  input  logic                  axis_wvalid,
  output logic                  axis_wready,
  output logic [DATA_WIDTH-1:0] axis_rdata,
  output logic                  axis_rvalid,
  input  logic                  axis_rready,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [NUM_CS-1:0]     spi_cs_n,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LEAD  = 3'd2,
    S_TRAIL = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t                r_state;
  logic [DIV_BITS-1:0]   r_cnt;
  logic [DIV_BITS-1:0]   r_div;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [LEN_W-1:0]      r_len;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsb;
  logic [LEN_W-1:0]      r_tidx;   // index of the next TX bit to present
  logic [LEN_W-1:0]      r_ridx;   // index where the next RX bit lands
  logic [LEN_W-1:0]      r_bit;    // completed LEAD/TRAIL pairs
  logic [NUM_CS-1:0]     r_cs_n;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_wready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_busy;

  logic                  w_tick;
  logic                  w_accept;
  logic                  w_rvalid_nxt;
  logic                  w_last;
  logic [NUM_CS-1:0]     w_cs_sel;
  logic [LEN_W-1:0]      w_first_idx;
  logic [LEN_W-1:0]      w_first_next;
  logic [LEN_W-1:0]      w_tnext;
  logic [LEN_W-1:0]      w_rnext;

  always_comb begin
    w_tick       = (r_cnt == '0);
    w_accept     = (r_state == S_IDLE) && axis_wvalid && r_wready;
    // Response valid as it will be after this edge; wready is registered, so
    // it has to look one edge ahead.
    w_rvalid_nxt = (r_rvalid && !axis_rready) || ((r_state == S_HOLD) && w_tick);
    w_last       = (r_bit == r_len);
    // Out-of-range target index leaves every chip select deasserted.
    w_cs_sel     = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      w_cs_sel[i] = !(axis_wcs == CS_W'(i));
    end
    w_first_idx  = axis_wmode[2] ? '0 : axis_wlen;
    w_first_next = axis_wmode[2] ? LEN_W'(1) : axis_wlen - LEN_W'(1);
    w_tnext      = r_lsb ? r_tidx + LEN_W'(1) : r_tidx - LEN_W'(1);
    w_rnext      = r_lsb ? r_ridx + LEN_W'(1) : r_ridx - LEN_W'(1);
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_len    <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_lsb    <= 1'b0;
      r_tidx   <= '0;
      r_ridx   <= '0;
      r_bit    <= '0;
      r_cs_n   <= '1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_wready <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (r_rvalid && axis_rready) begin
        r_rvalid <= 1'b0;
      end

      // Half-period divider: reloaded on every state entry, so each non-IDLE
      // state lasts exactly r_div+1 cycles.
      if (r_state != S_IDLE) begin
        r_cnt <= w_tick ? r_div : r_cnt - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_wready <= !w_accept && !w_rvalid_nxt;
          if (w_accept) begin
            r_state <= S_SETUP;
            r_cnt   <= cfg_div;
            r_div   <= cfg_div;
            r_tx    <= axis_wdata;
            r_rx    <= '0;
            r_len   <= axis_wlen;
            r_cpol  <= axis_wmode[0];
            r_cpha  <= axis_wmode[1];
            r_lsb   <= axis_wmode[2];
            r_bit   <= '0;
            r_ridx  <= w_first_idx;
            r_cs_n  <= w_cs_sel;
            r_sclk  <= axis_wmode[0];
            r_busy  <= 1'b1;
            if (!axis_wmode[1]) begin
              // CPHA=0: first bit must be on the wire before the first edge.
              r_mosi <= axis_wdata[w_first_idx];
              r_tidx <= w_first_next;
            end else begin
              r_mosi <= 1'b0;
              r_tidx <= w_first_idx;
            end
          end
        end

        S_SETUP: begin
          if (w_tick) begin
            r_state <= S_LEAD;
            r_sclk  <= !r_cpol;
            if (!r_cpha) begin
              r_rx[r_ridx] <= spi_miso;
              r_ridx       <= w_rnext;
            end else begin
              r_mosi <= r_tx[r_tidx];
              r_tidx <= w_tnext;
            end
          end
        end

        S_LEAD: begin
          if (w_tick) begin
            r_state <= S_TRAIL;
            r_sclk  <= r_cpol;
            if (r_cpha) begin
              r_rx[r_ridx] <= spi_miso;
              r_ridx       <= w_rnext;
            end else if (!w_last) begin
              // Last bit stays on MOSI through HOLD.
              r_mosi <= r_tx[r_tidx];
              r_tidx <= w_tnext;
            end
          end
        end

        S_TRAIL: begin
          if (w_tick) begin
            if (w_last) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_LEAD;
              r_bit   <= r_bit + 1'b1;
              r_sclk  <= !r_cpol;
              if (!r_cpha) begin
                r_rx[r_ridx] <= spi_miso;
                r_ridx       <= w_rnext;
              end else begin
                r_mosi <= r_tx[r_tidx];
                r_tidx <= w_tnext;
              end
            end
          end
        end

        S_HOLD: begin
          if (w_tick) begin
            r_state  <= S_GAP;
            r_cs_n   <= '1;
            r_rdata  <= r_rx;
            r_rvalid <= 1'b1;
            r_mosi   <= 1'b0;
          end
        end

        S_GAP: begin
          if (w_tick) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_wready <= !w_rvalid_nxt;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign axis_wready = r_wready;
  assign axis_rvalid = r_rvalid;
  assign axis_rdata  = r_rdata;
  assign spi_sclk    = r_sclk;
  assign spi_mosi    = r_mosi;
  assign spi_cs_n    = r_cs_n;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule
